// File: rtl/registros_pkg.sv
// Shared types and sizes for the Registros bank and its read-side companion.
package registros_pkg;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [WIDTH-1:0]  word_t;
    typedef word_t [DEPTH-1:0] bank_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Reader FSM states; the encoding is also what the debug state port shows.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } lector_state_e;

endpackage

// File: rtl/registros_ocupacion.sv
// Occupancy tracker for the shift bank: saturating up-counter driven by the
// bank's push strobe, with a subtract-on-clear input used after a read.
module registros_ocupacion #(
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          clr_i,
    input  logic [CW-1:0] clr_amt_i,
    output logic [CW-1:0] count_o
);
    import registros_pkg::*;

    localparam logic [CW+1:0] MAX_W = (CW+2)'(DEPTH);
    localparam logic [CW-1:0] MAX_C = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW+1:0] w_sum;
    logic [CW+1:0] w_amt;
    logic [CW+1:0] w_diff;
    logic [CW-1:0] w_next;

    // Next count: clear subtracts the words just read (floored at 0, capped at
    // DEPTH) while still honouring a push in the same cycle; otherwise count up.
    always_comb begin
        w_sum  = {2'b00, r_count} + {{(CW+1){1'b0}}, push_i};
        w_amt  = {2'b00, clr_amt_i};
        w_diff = w_sum - w_amt;
        w_next = r_count;
        if (clr_i) begin
            if (w_sum <= w_amt) begin
                w_next = '0;
            end else if (w_diff >= MAX_W) begin
                w_next = MAX_C;
            end else begin
                w_next = w_diff[CW-1:0];
            end
        end else if (push_i && (r_count != MAX_C)) begin
            w_next = r_count + CW'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/registros_lector.sv
// Read-side companion to the Registros shift bank. Tracks occupancy from the
// bank's push strobe and, on request, snapshots the bank and streams the valid
// entries oldest-first.
//
// Handshake: data_o/last_o are meaningful while valid_o is high; a word is
// transferred on a rising clk_i edge where valid_o && ready_i. Once raised,
// valid_o, data_o and last_o hold until that transfer. All outputs are
// registered; ready_i never reaches valid_o combinationally.
module registros_lector #(
    parameter int DEPTH         = 32,
    parameter int WIDTH         = 32,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]   regs_i,
    input  logic                          start_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          last_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [1:0]                    state_o
);
    import registros_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    lector_state_e                 r_state;
    logic [DEPTH-1:0][WIDTH-1:0]   r_snap;
    logic [CW-1:0]                 r_snap_cnt;
    logic [IW-1:0]                 r_idx;
    logic [WIDTH-1:0]              r_data;
    logic                          r_valid;
    logic                          r_last;
    logic                          r_done;

    logic [CW-1:0]                 w_count;
    logic [CW-1:0]                 w_cnt_m1;
    logic                          w_hs;
    logic                          w_clr;

    assign w_cnt_m1 = w_count - CW'(1);
    assign w_hs     = r_valid & ready_i;
    assign w_clr    = CLEAR_ON_READ & (r_state == FINISH);

    registros_ocupacion #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ocupacion (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_i),
        .clr_i     (w_clr),
        .clr_amt_i (r_snap_cnt),
        .count_o   (w_count)
    );

    // Reader FSM: snapshot on start, present words newest-index-last (oldest
    // first) by walking idx down to 0, then pulse done for one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_snap     <= '0;
            r_snap_cnt <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (w_count != '0) begin
                            // Pre-push bank contents and count of this cycle.
                            r_snap     <= regs_i;
                            r_snap_cnt <= w_count;
                            r_idx      <= w_cnt_m1[IW-1:0];
                            r_state    <= LOAD;
                        end else begin
                            r_snap_cnt <= '0;
                            r_state    <= FINISH;
                        end
                    end
                end
                LOAD: begin
                    r_data  <= r_snap[r_idx];
                    r_valid <= 1'b1;
                    r_last  <= (r_idx == '0);
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (w_hs) begin
                        if (r_idx == '0) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= FINISH;
                        end else begin
                            r_idx  <= r_idx - IW'(1);
                            r_data <= r_snap[r_idx - IW'(1)];
                            r_last <= (r_idx == IW'(1));
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign done_o  = r_done;
    assign busy_o  = (r_state != IDLE);
    assign count_o = w_count;
    assign state_o = r_state;

endmodule

// File: tb/tb_registros_lector.sv
// Directed bench for registros_lector with a behavioural model of the shift bank.
module tb_registros_lector;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                        clk_i   = 1'b0;
    logic                        rst_i   = 1'b0;
    logic                        push_i  = 1'b0;
    logic                        start_i = 1'b0;
    logic                        ready_i = 1'b0;
    logic [WIDTH-1:0]            data_i  = '0;
    logic [DEPTH-1:0][WIDTH-1:0] bank    = '0;

    logic [WIDTH-1:0]            data_o;
    logic                        valid_o;
    logic                        last_o;
    logic                        done_o;
    logic                        busy_o;
    logic [CW-1:0]               count_o;
    logic [1:0]                  state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] exp_q[$];

    registros_lector #(
        .DEPTH         (DEPTH),
        .WIDTH         (WIDTH),
        .CLEAR_ON_READ (1'b1)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_i),
        .regs_i  (bank),
        .start_i (start_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .count_o (count_o),
        .state_o (state_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    // shift bank model: entry 0 newest
    always @(posedge clk_i) begin
        if (push_i) bank <= {bank[DEPTH-2:0], data_i};
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        data_i = w;
        push_i = 1'b1;
        tick();
        push_i = 1'b0;
    endtask

    // Issue start and consume the stream against exp_q.
    task automatic run_read(input int n, input bit toggle, input int push_cyc,
                            input logic [31:0] push_val, input logic [31:0] exp_cnt);
        int hs;
        int k;
        int done_cyc;
        bit held_v;
        logic [31:0] held_d;
        logic [31:0] e;
        logic [3:0] pat;
        pat      = 4'b1001;
        hs       = 0;
        k        = 0;
        done_cyc = -1;
        held_v   = 1'b0;
        held_d   = '0;
        ready_i  = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        check_eq("busy_after_start", {31'd0, busy_o}, 1);
        check_eq("valid_after_start", {31'd0, valid_o}, 0);
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            ready_i = toggle ? pat[k % 4] : 1'b1;
            if (valid_o) begin
                if (held_v) begin
                    check_eq("stall_hold", data_o, held_d);
                    held_v = 1'b0;
                end
                if (ready_i) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    check_eq("word", data_o, e);
                    check_eq("last", {31'd0, last_o}, {31'd0, (exp_q.size() == 0)});
                    hs++;
                end else begin
                    held_d = data_o;
                    held_v = 1'b1;
                end
                k++;
            end
            push_i = (cyc == push_cyc);
            data_i = push_val;
            tick();
            if (done_o) done_cyc = cyc;
        end
        push_i  = 1'b0;
        ready_i = 1'b0;
        check_eq("done_seen", {31'd0, (done_cyc >= 0)}, 1);
        check_eq("handshakes", hs, n);
        if (!toggle) check_eq("done_latency", done_cyc, (n == 0) ? 0 : n + 1);
        check_eq("valid_at_done", {31'd0, valid_o}, 0);
        check_eq("busy_at_done", {31'd0, busy_o}, 0);
        check_eq("count_after_read", {26'd0, count_o}, exp_cnt);
        tick();
        check_eq("done_one_cycle", {31'd0, done_o}, 0);
        exp_q.delete();
    endtask

    initial begin
        // reset
        rst_i = 1'b0;
        tick();
        tick();
        check_eq("rst_data", data_o, 0);
        check_eq("rst_valid", {31'd0, valid_o}, 0);
        check_eq("rst_last", {31'd0, last_o}, 0);
        check_eq("rst_done", {31'd0, done_o}, 0);
        check_eq("rst_busy", {31'd0, busy_o}, 0);
        check_eq("rst_count", {26'd0, count_o}, 0);
        check_eq("rst_state", {30'd0, state_o}, 0);
        rst_i = 1'b1;
        tick();

        // basic fill and full-rate read
        push_word(32'hF2F2);
        push_word(32'hA1A1);
        push_word(32'hFFFF);
        push_word(32'h2222);
        check_eq("count_4", {26'd0, count_o}, 4);
        exp_q = '{32'hF2F2, 32'hA1A1, 32'hFFFF, 32'h2222};
        run_read(4, 1'b0, -1, 32'h0, 0);

        // same fill, ready toggling 1-0-0-1
        push_word(32'hF2F2);
        push_word(32'hA1A1);
        push_word(32'hFFFF);
        push_word(32'h2222);
        exp_q = '{32'hF2F2, 32'hA1A1, 32'hFFFF, 32'h2222};
        run_read(4, 1'b1, -1, 32'h0, 0);

        // empty read
        run_read(0, 1'b0, -1, 32'h0, 0);

        // push during stream does not disturb the snapshot
        push_word(32'h1111);
        push_word(32'h5555);
        exp_q = '{32'h1111, 32'h5555};
        run_read(2, 1'b0, 2, 32'h3333, 1);

        // saturation: 40 pushes keep the newest 32
        for (int i = 0; i < 40; i++) push_word(32'h1000 + i);
        check_eq("count_sat", {26'd0, count_o}, 32);
        for (int i = 8; i < 40; i++) exp_q.push_back(32'h1000 + i);
        run_read(32, 1'b0, -1, 32'h0, 0);

        // reset in the middle of a stream
        push_word(32'h000A);
        push_word(32'h000B);
        push_word(32'h000C);
        push_word(32'h000D);
        ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check_eq("mid_valid", {31'd0, valid_o}, 1);
        check_eq("mid_word", data_o, 32'h000B);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, valid_o}, 0);
        check_eq("arst_busy", {31'd0, busy_o}, 0);
        check_eq("arst_count", {26'd0, count_o}, 0);
        tick();
        check_eq("arst_no_done_a", {31'd0, done_o}, 0);
        rst_i = 1'b1;
        tick();
        check_eq("arst_no_done_b", {31'd0, done_o}, 0);
        ready_i = 1'b0;
        run_read(0, 1'b0, -1, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
